// File: rtl/overlay_gen.sv
// Overlay pattern source: one frame of {mask, frame, addr, pixels} per start; first word 1 cycle after start edge; dout held while valid & ~ready.
// OVERLAY_GEN_CONTINUOUS_EN: frames run back-to-back, done is a 1-cycle pulse and done_ack is ignored.
module overlay_gen #(
    parameter int N_ROW        = 300,
    parameter int N_COL        = 400,
    parameter int PIX_PER_WORD = 4,
    parameter int PIX_W        = 8,
    parameter int MASK_W       = 16,
    parameter int MASK_DEPTH   = 64,
    parameter int ADDR_W       = 17,
    parameter logic [PIX_W-1:0] SOLID_VALUE = 8'h80,
    // Mask table image: entry i lives at bits [i*MASK_W +: MASK_W].
    parameter logic [MASK_DEPTH*MASK_W-1:0] MASK_INIT = '0
) (
    input  logic                                     clock_i,
    input  logic                                     reset_i,
    input  logic [1:0]                               mode_i,
    input  logic                                     scroll_i,
    input  logic                                     start_i,
    output logic                                     start_ack_o,
    output logic                                     done_o,
    input  logic                                     done_ack_i,
    output logic [MASK_W+ADDR_W+PIX_PER_WORD*PIX_W:0] dout_o,
    output logic                                     valid_o,
    input  logic                                     ready_i
);

    localparam int WPR      = N_COL / PIX_PER_WORD;
    localparam int WORDS    = N_ROW * WPR;
    localparam int MAX_ADDR = WORDS - 1;
    localparam int ROW_W    = (N_ROW > 1) ? $clog2(N_ROW) : 1;
    localparam int WCOL_W   = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int IDX_W    = (MASK_DEPTH > 1) ? $clog2(MASK_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                start_ack_q, start_ack_r_q;
    logic                start_edge, accept, last_word;
    logic [1:0]          mode_r_q;
    logic                scroll_r_q;
    logic                frame_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ROW_W-1:0]    row_q;
    logic [WCOL_W-1:0]   wcol_q;
    logic [IDX_W-1:0]    idx_q;
    logic [PIX_W-1:0]    offset_q;
`ifdef OVERLAY_GEN_CONTINUOUS_EN
    logic                done_q;
`endif

    assign start_ack_o = start_ack_q;
    assign start_edge  = start_ack_q & ~start_ack_r_q;
    assign accept      = valid_o & ready_i;
    assign last_word   = accept & (addr_q == ADDR_W'(MAX_ADDR));

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_edge) state_d = S_RUN;
`ifdef OVERLAY_GEN_CONTINUOUS_EN
            S_RUN:  state_d = S_RUN;
`else
            S_RUN:  if (last_word) state_d = S_DONE;
`endif
            S_DONE: if (done_ack_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        valid_o = (state_q == S_RUN);
`ifdef OVERLAY_GEN_CONTINUOUS_EN
        done_o  = done_q;
`else
        done_o  = (state_q == S_DONE);
`endif
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            start_ack_q   <= 1'b0;
            start_ack_r_q <= 1'b0;
            mode_r_q      <= '0;
            scroll_r_q    <= 1'b0;
            frame_q       <= 1'b1;
            addr_q        <= '0;
            row_q         <= '0;
            wcol_q        <= '0;
            idx_q         <= '0;
            offset_q      <= '0;
`ifdef OVERLAY_GEN_CONTINUOUS_EN
            done_q        <= 1'b0;
`endif
        end else begin
            start_ack_q   <= start_i;
            start_ack_r_q <= start_ack_q;
`ifdef OVERLAY_GEN_CONTINUOUS_EN
            done_q        <= last_word;
`endif
            if (state_q == S_IDLE && start_edge) begin
                mode_r_q   <= mode_i;
                scroll_r_q <= scroll_i;
                addr_q     <= '0;
                row_q      <= '0;
                wcol_q     <= '0;
                idx_q      <= '0;
            end else if (last_word) begin
                frame_q  <= ~frame_q;
                offset_q <= scroll_r_q ? offset_q + 1'b1 : '0;
                addr_q   <= '0;
                row_q    <= '0;
                wcol_q   <= '0;
                idx_q    <= '0;
`ifdef OVERLAY_GEN_CONTINUOUS_EN
                mode_r_q   <= mode_i;
                scroll_r_q <= scroll_i;
`endif
            end else if (accept) begin
                addr_q <= addr_q + 1'b1;
                idx_q  <= (idx_q == IDX_W'(MASK_DEPTH-1)) ? '0 : idx_q + 1'b1;
                if (wcol_q == WCOL_W'(WPR-1)) begin
                    wcol_q <= '0;
                    row_q  <= row_q + 1'b1;
                end else begin
                    wcol_q <= wcol_q + 1'b1;
                end
            end
        end
    end

    logic [MASK_W-1:0] mask_tab [MASK_DEPTH];
    for (genvar i = 0; i < MASK_DEPTH; i++) begin : g_mask
        assign mask_tab[i] = MASK_INIT[i*MASK_W +: MASK_W];
    end

    // Arithmetic is done modulo 2^PIX_W; the checkerboard only needs bit 3 of row and col.
    logic [PIX_PER_WORD*PIX_W-1:0] pix;
    logic [PIX_W-1:0]              col_v, row_v, lane_v;
    always_comb begin
        pix    = '0;
        col_v  = '0;
        lane_v = '0;
        row_v  = PIX_W'(row_q);
        for (int k = 0; k < PIX_PER_WORD; k++) begin
            col_v = PIX_W'(wcol_q) * PIX_W'(PIX_PER_WORD) + PIX_W'(k) + offset_q;
            case (mode_r_q)
                2'd0:    lane_v = SOLID_VALUE;
                2'd1:    lane_v = col_v;
                2'd2:    lane_v = row_v + offset_q;
                default: lane_v = (row_v[3] ^ col_v[3]) ? '1 : '0;
            endcase
            pix[k*PIX_W +: PIX_W] = lane_v;
        end
    end

    assign dout_o = {mask_tab[idx_q], frame_q, addr_q, pix};

endmodule

// File: tb/tb_overlay_gen.sv
// Scoreboard bench for overlay_gen: 2x8 frame instance (modes 0/1/2, stalls, scroll, reset) and a 16x16 checkerboard instance.
module tb_overlay_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: N_ROW=2, N_COL=8, 4 px/word, mask table {AAAA, 5555}
    logic        rst_a, scroll_a, start_a, start_ack_a, done_a, done_ack_a, valid_a, ready_a;
    logic [1:0]  mode_a;
    logic [51:0] dout_a;

    overlay_gen #(
        .N_ROW(2), .N_COL(8), .PIX_PER_WORD(4), .PIX_W(8), .MASK_W(16),
        .MASK_DEPTH(2), .ADDR_W(3), .MASK_INIT(32'h5555_AAAA)
    ) u_dut_a (
        .clock_i(clk), .reset_i(rst_a), .mode_i(mode_a), .scroll_i(scroll_a),
        .start_i(start_a), .start_ack_o(start_ack_a), .done_o(done_a),
        .done_ack_i(done_ack_a), .dout_o(dout_a), .valid_o(valid_a), .ready_i(ready_a)
    );

    // Instance B: 16x16 checkerboard
    logic        rst_b, scroll_b, start_b, start_ack_b, done_b, done_ack_b, valid_b, ready_b;
    logic [1:0]  mode_b;
    logic [54:0] dout_b;

    overlay_gen #(
        .N_ROW(16), .N_COL(16), .PIX_PER_WORD(4), .PIX_W(8), .MASK_W(16),
        .MASK_DEPTH(64), .ADDR_W(6)
    ) u_dut_b (
        .clock_i(clk), .reset_i(rst_b), .mode_i(mode_b), .scroll_i(scroll_b),
        .start_i(start_b), .start_ack_o(start_ack_b), .done_o(done_b),
        .done_ack_i(done_ack_b), .dout_o(dout_b), .valid_o(valid_b), .ready_i(ready_b)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard for instance A
    logic [51:0] exp_q [$];
    logic [51:0] prev_dout, exp_w;
    logic        prev_stall = 1'b0;
    logic        prev_last  = 1'b0;
    int          acc_cnt    = 0;

    always @(negedge clk) begin
        if (prev_stall && valid_a)
            chk("stall_hold", 64'(dout_a), 64'(prev_dout));
        if (prev_last) begin
            chk("done_after_last", 64'(done_a), 64'd1);
            chk("valid_after_last", 64'(valid_a), 64'd0);
        end
        prev_stall = valid_a && !ready_a;
        prev_last  = 1'b0;
        if (valid_a && ready_a) begin
            acc_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 64'(dout_a), 64'd0);
            end else begin
                exp_w = exp_q.pop_front();
                chk("word", 64'(dout_a), 64'(exp_w));
            end
            prev_last = (dout_a[34:32] == 3'd3);
        end
        prev_dout = dout_a;
    end

    // Checker for instance B
    logic [31:0] cap_b [64];
    logic [31:0] exp_b;
    int          cnt_b = 0;
    int          a_b, r_b, w_b;

    always @(negedge clk) begin
        if (valid_b && ready_b) begin
            a_b = int'(dout_b[37:32]);
            r_b = a_b / 4;
            w_b = a_b % 4;
            exp_b = ((((r_b >> 3) ^ (w_b >> 1)) & 1) != 0) ? 32'hFFFF_FFFF : 32'h0;
            chk("ckr_addr", 64'(a_b), 64'(cnt_b));
            chk("ckr_word", 64'(dout_b[31:0]), 64'(exp_b));
            cap_b[a_b] = dout_b[31:0];
            cnt_b++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_w(input logic [15:0] m, input logic fr, input logic [2:0] ad, input logic [31:0] px);
        exp_q.push_back({m, fr, ad, px});
    endtask

    task automatic push_frame(input logic fr, input logic [31:0] p0, input logic [31:0] p1,
                              input logic [31:0] p2, input logic [31:0] p3);
        push_w(16'hAAAA, fr, 3'd0, p0);
        push_w(16'h5555, fr, 3'd1, p1);
        push_w(16'hAAAA, fr, 3'd2, p2);
        push_w(16'h5555, fr, 3'd3, p3);
    endtask

    task automatic pulse_start();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done_a && t < 100) begin
            tick();
            t++;
        end
        chk("done_seen", 64'(done_a), 64'd1);
    endtask

    task automatic ack_done();
        done_ack_a = 1'b1;
        tick();
        done_ack_a = 1'b0;
        chk("done_clear", 64'(done_a), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst_a = 1'b0; mode_a = 2'd0; scroll_a = 1'b0; start_a = 1'b0; done_ack_a = 1'b0; ready_a = 1'b0;
        rst_b = 1'b0; mode_b = 2'd3; scroll_b = 1'b0; start_b = 1'b0; done_ack_b = 1'b0; ready_b = 1'b1;
        repeat (3) tick();
        rst_a = 1'b1;
        tick();

        // Reset state
        chk("rst_valid", 64'(valid_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_start_ack", 64'(start_ack_a), 64'd0);
        chk("rst_frame", 64'(dout_a[35]), 64'd1);
        chk("rst_addr", 64'(dout_a[34:32]), 64'd0);
        chk("rst_mask", 64'(dout_a[51:36]), 64'hAAAA);

        // Test 1: horizontal gradient, start held 3 cycles
        mode_a = 2'd1; scroll_a = 1'b0; ready_a = 1'b1; acc_cnt = 0;
        push_frame(1'b1, 32'h03020100, 32'h07060504, 32'h03020100, 32'h07060504);
        start_a = 1'b1;
        tick();
        chk("t1_start_ack", 64'(start_ack_a), 64'd1);
        chk("t1_valid_lat0", 64'(valid_a), 64'd0);
        tick();
        chk("t1_valid_lat1", 64'(valid_a), 64'd1);
        tick();
        start_a = 1'b0;
        wait_done();
        chk("t1_accepts", 64'(acc_cnt), 64'd4);
        chk("t1_frame_after", 64'(dout_a[35]), 64'd0);
        ack_done();

        // Test 2: ready 1,0,0,1 during RUN
        acc_cnt = 0;
        push_frame(1'b0, 32'h03020100, 32'h07060504, 32'h03020100, 32'h07060504);
        pulse_start();
        tick();
        tick();
        ready_a = 1'b0;
        tick();
        tick();
        chk("t2_hold_addr", 64'(dout_a[34:32]), 64'd1);
        chk("t2_hold_valid", 64'(valid_a), 64'd1);
        ready_a = 1'b1;
        wait_done();
        chk("t2_accepts", 64'(acc_cnt), 64'd4);
        ack_done();

        // Test 3: scroll over two frames; mode/scroll changes mid-frame are ignored
        mode_a = 2'd1; scroll_a = 1'b1;
        push_frame(1'b1, 32'h03020100, 32'h07060504, 32'h03020100, 32'h07060504);
        pulse_start();
        wait_done();
        chk("t3_frame_a", 64'(dout_a[35]), 64'd0);
        ack_done();
        push_frame(1'b0, 32'h04030201, 32'h08070605, 32'h04030201, 32'h08070605);
        pulse_start();
        tick();
        mode_a = 2'd2; scroll_a = 1'b0;
        wait_done();
        chk("t3_frame_b", 64'(dout_a[35]), 64'd1);
        ack_done();

        // Test 5a: start pulses in RUN and DONE are dropped
        mode_a = 2'd0; scroll_a = 1'b0; ready_a = 1'b0; acc_cnt = 0;
        push_frame(1'b1, 32'h80808080, 32'h80808080, 32'h80808080, 32'h80808080);
        pulse_start();
        tick();
        pulse_start();
        repeat (3) tick();
        chk("t5_run_addr", 64'(dout_a[34:32]), 64'd0);
        chk("t5_run_valid", 64'(valid_a), 64'd1);
        ready_a = 1'b1;
        wait_done();
        chk("t5_accepts", 64'(acc_cnt), 64'd4);
        pulse_start();
        repeat (4) tick();
        chk("t5_done_hold", 64'(done_a), 64'd1);
        chk("t5_done_novalid", 64'(valid_a), 64'd0);
        ack_done();
        seen = 1'b0;
        repeat (6) begin
            tick();
            seen = seen | valid_a;
        end
        chk("t5_no_restart", 64'(seen), 64'd0);

        // Test 5b: reset while addr 2 is presented
        mode_a = 2'd1;
        push_w(16'hAAAA, 1'b0, 3'd0, 32'h03020100);
        push_w(16'h5555, 1'b0, 3'd1, 32'h07060504);
        pulse_start();
        begin
            int t = 0;
            while (!(valid_a && dout_a[34:32] == 3'd2) && t < 20) begin
                tick();
                t++;
            end
        end
        chk("t5_reach_addr2", 64'(dout_a[34:32]), 64'd2);
        rst_a = 1'b0;
        ready_a = 1'b0;
        tick();
        tick();
        rst_a = 1'b1;
        ready_a = 1'b1;
        chk("t5r_valid", 64'(valid_a), 64'd0);
        chk("t5r_done", 64'(done_a), 64'd0);
        chk("t5r_frame", 64'(dout_a[35]), 64'd1);
        chk("t5r_addr", 64'(dout_a[34:32]), 64'd0);
        chk("t5r_pending", 64'(exp_q.size()), 64'd0);
        seen = 1'b0;
        repeat (8) begin
            tick();
            seen = seen | done_a | valid_a;
        end
        chk("t5r_no_done", 64'(seen), 64'd0);

        // Test 6: vertical gradient frame, mask sequence restarts at AAAA
        mode_a = 2'd2; scroll_a = 1'b0;
        push_frame(1'b1, 32'h00000000, 32'h00000000, 32'h01010101, 32'h01010101);
        pulse_start();
        wait_done();
        ack_done();
        chk("a_queue_empty", 64'(exp_q.size()), 64'd0);

        // Test 4: 16x16 checkerboard on instance B
        rst_b = 1'b1;
        tick();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        begin
            int t = 0;
            while (!done_b && t < 200) begin
                tick();
                t++;
            end
        end
        chk("b_done", 64'(done_b), 64'd1);
        chk("b_words", 64'(cnt_b), 64'd64);
        chk("ckr_r0_c8", 64'(cap_b[2]), 64'hFFFF_FFFF);
        chk("ckr_r8_c8", 64'(cap_b[34]), 64'h0);
        chk("ckr_r0_c0", 64'(cap_b[0]), 64'h0);
        chk("ckr_r8_c0", 64'(cap_b[32]), 64'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
